// File: rtl/grd_pkg.sv
// Shared types and widths for the Golomb-Rice decoder.
// Imported by golomb_rice_decoder.
package grd_pkg;

  localparam int DW = 32;
  localparam int KW = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFIX,
    ST_REM,
    ST_SIGN,
    ST_DONE
  } grd_state_e;

endpackage

// File: rtl/golomb_rice_decoder.sv
// Serial Golomb-Rice codeword decoder (unary prefix, k-bit remainder, sign).
// Optional macro GRD_PREFIX_LIMIT_EN enables the Q_LIMIT prefix error.
module golomb_rice_decoder
  import grd_pkg::*;
#(
  parameter int Q_LIMIT = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [KW-1:0] k,
  input  logic          is_ac_level,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          bit_ready,
  output logic [DW-1:0] val,
  output logic          is_minus,
  output logic [DW-1:0] codeword_length,
  output logic          err,
  output logic          out_valid,
  input  logic          out_ready
);

  grd_state_e    state_q;
  logic [KW-1:0] k_q;
  logic [KW-1:0] cnt_q;
  logic          ac_q;
  logic [DW-1:0] val_q;
  logic [DW-1:0] len_q;
  logic          minus_q;

  // val_q counts q during the prefix, then shifts in remainder bits,
  // which yields (q << k) | rem without a separate q register.
`ifdef GRD_PREFIX_LIMIT_EN
  logic err_q;
  assign err = err_q;
`else
  localparam int unused_q_limit = Q_LIMIT;
  assign err = 1'b0;
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign bit_ready = (state_q == ST_PREFIX) ||
                     (state_q == ST_REM) ||
                     (state_q == ST_SIGN);

  assign val             = val_q;
  assign is_minus        = minus_q;
  assign codeword_length = len_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      ac_q    <= 1'b0;
      val_q   <= '0;
      len_q   <= '0;
      minus_q <= 1'b0;
`ifdef GRD_PREFIX_LIMIT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            k_q     <= k;
            ac_q    <= is_ac_level;
            cnt_q   <= '0;
            val_q   <= '0;
            len_q   <= '0;
            minus_q <= 1'b0;
`ifdef GRD_PREFIX_LIMIT_EN
            err_q   <= 1'b0;
`endif
            state_q <= ST_PREFIX;
          end
        end
        ST_PREFIX: begin
          if (bit_valid) begin
            len_q <= len_q + 1'b1;
            if (!bit_in) begin
`ifdef GRD_PREFIX_LIMIT_EN
              if (val_q == DW'(Q_LIMIT)) begin
                err_q   <= 1'b1;
                val_q   <= '0;
                state_q <= ST_DONE;
              end else begin
                val_q <= val_q + 1'b1;
              end
`else
              val_q <= val_q + 1'b1;
`endif
            end else if (k_q != '0) begin
              cnt_q   <= k_q;
              state_q <= ST_REM;
            end else if (ac_q) begin
              state_q <= ST_SIGN;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_REM: begin
          if (bit_valid) begin
            len_q <= len_q + 1'b1;
            val_q <= {val_q[DW-2:0], bit_in};
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == KW'(1)) begin
              state_q <= ac_q ? ST_SIGN : ST_DONE;
            end
          end
        end
        ST_SIGN: begin
          if (bit_valid) begin
            len_q   <= len_q + 1'b1;
            minus_q <= bit_in;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_golomb_rice_decoder.sv
// Randomized self-checking bench for golomb_rice_decoder.
// Expected results come from a codeword-level model built from q/k/rem/sign.
module tb_golomb_rice_decoder;

  localparam int QL = 24;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  k;
  logic        is_ac_level;
  logic        bit_in;
  logic        bit_valid;
  logic        bit_ready;
  logic [31:0] val;
  logic        is_minus;
  logic [31:0] codeword_length;
  logic        err;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  golomb_rice_decoder #(.Q_LIMIT(QL)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .k               (k),
    .is_ac_level     (is_ac_level),
    .bit_in          (bit_in),
    .bit_valid       (bit_valid),
    .bit_ready       (bit_ready),
    .val             (val),
    .is_minus        (is_minus),
    .codeword_length (codeword_length),
    .err             (err),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checks++;
      if (cmd_ready === 1'b1 && bit_ready === 1'b1) begin
        failures++;
        $display("FAIL ready_exclusive: cmd_ready=1 bit_ready=1 required not both");
      end
    end
  end

  task automatic decode_one(input int q, input int kk, input int rem,
                            input bit ac, input bit sg, input int gap_at,
                            input int gap_n, input int hold);
    bit          bq[$];
    logic [31:0] ev;
    logic [31:0] elen;
    logic [31:0] pv;
    logic [31:0] pl;
    logic        em;
    logic        eerr;
    bit          early;
    bit          br_bad;
    int          n;
    repeat (q) bq.push_back(1'b0);
    bq.push_back(1'b1);
    for (int i = kk - 1; i >= 0; i--) bq.push_back(rem[i]);
    if (ac) bq.push_back(sg);
    ev   = (32'(q) << kk) | 32'(rem);
    em   = ac & sg;
    elen = 32'(bq.size());
    eerr = 1'b0;
`ifdef GRD_PREFIX_LIMIT_EN
    if (q > QL) begin
      bq.delete();
      repeat (QL + 1) bq.push_back(1'b0);
      ev = 0; em = 0; elen = 32'(QL + 1); eerr = 1'b1;
    end
`endif
    k = 3'(kk);
    is_ac_level = ac;
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL cmd_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    early = 0;
    br_bad = 0;
    for (int i = 0; i < bq.size(); i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_n; g++) begin
          bit_valid = 1'b0;
          pv = val; pl = codeword_length;
          @(posedge clk); #1;
          checks++;
          if (bit_ready !== 1'b1 || out_valid !== 1'b0 ||
              val !== pv || codeword_length !== pl) begin
            failures++;
            $display("FAIL stall: val=%0d len=%0d br=%b ov=%b required val=%0d len=%0d br=1 ov=0",
                     val, codeword_length, bit_ready, out_valid, pv, pl);
          end
        end
      end
      bit_valid = 1'b1;
      bit_in = bq[i];
      if (bit_ready !== 1'b1) br_bad = 1;
      @(posedge clk); #1;
      if (i < bq.size() - 1 && out_valid !== 1'b0) early = 1;
    end
    bit_valid = 1'b0;
    checks++;
    if (early || br_bad) begin
      failures++;
      $display("FAIL bit_phase: early_out_valid=%b bit_ready_low=%b required 0 0", early, br_bad);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL out_valid_timing: out_valid=%b required 1 after last bit", out_valid);
    end
    checks++;
    if (val !== ev || is_minus !== em || codeword_length !== elen || err !== eerr) begin
      failures++;
      $display("FAIL result q=%0d k=%0d rem=%0d ac=%0d: val=%0d minus=%b len=%0d err=%b required val=%0d minus=%b len=%0d err=%b",
               q, kk, rem, ac, val, is_minus, codeword_length, err, ev, em, elen, eerr);
    end
    checks++;
    if (cmd_ready !== 1'b0 || bit_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_ready: cmd_ready=%b bit_ready=%b required 0 0", cmd_ready, bit_ready);
    end
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || val !== ev || codeword_length !== elen ||
          is_minus !== em || cmd_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold: ov=%b val=%0d len=%0d cr=%b required ov=1 val=%0d len=%0d cr=0",
                 out_valid, val, codeword_length, cmd_ready, ev, elen);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL release: out_valid=%b cmd_ready=%b required 0 1", out_valid, cmd_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_valid = 0; k = 0; is_ac_level = 0;
    bit_in = 0; bit_valid = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (val !== 0 || codeword_length !== 0 || is_minus !== 0 || err !== 0 ||
        out_valid !== 0 || bit_ready !== 0 || cmd_ready !== 1) begin
      failures++;
      $display("FAIL reset_state: val=%0d len=%0d minus=%b err=%b ov=%b br=%b cr=%b required 0 0 0 0 0 0 1",
               val, codeword_length, is_minus, err, out_valid, bit_ready, cmd_ready);
    end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    decode_one(3, 2, 1, 0, 0, -1, 0, 0);
    decode_one(2, 0, 0, 1, 1, -1, 0, 1);
    decode_one(0, 3, 7, 1, 0, 2, 2, 0);
  endtask

  task automatic test_back_to_back();
    decode_one(1, 1, 0, 0, 0, -1, 0, 3);
    decode_one(4, 7, 127, 1, 1, -1, 0, 0);
    decode_one(0, 0, 0, 0, 0, -1, 0, 0);
  endtask

  task automatic test_reset_mid();
    k = 3'd1; is_ac_level = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bit_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (val !== 0 || codeword_length !== 0 || out_valid !== 0 ||
        cmd_ready !== 1 || bit_ready !== 0) begin
      failures++;
      $display("FAIL reset_mid: val=%0d len=%0d ov=%b cr=%b br=%b required 0 0 0 1 0",
               val, codeword_length, out_valid, cmd_ready, bit_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bit_valid = 1'b0;
    checks++;
    if (out_valid !== 0 || cmd_ready !== 1) begin
      failures++;
      $display("FAIL reset_discard: out_valid=%b cmd_ready=%b required 0 1", out_valid, cmd_ready);
    end
    decode_one(0, 1, 1, 0, 0, -1, 0, 0);
  endtask

  task automatic test_prefix_limit();
    decode_one(25, 0, 0, 0, 0, -1, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int q, kk, rem, gat, gn, hold;
      bit ac, sg;
      q    = $urandom_range(0, 12);
      kk   = $urandom_range(0, 7);
      rem  = (kk == 0) ? 0 : $urandom_range(0, (1 << kk) - 1);
      ac   = 1'($urandom_range(0, 1));
      sg   = 1'($urandom_range(0, 1));
      gat  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, q + kk) : -1;
      gn   = $urandom_range(1, 3);
      hold = $urandom_range(0, 3);
      decode_one(q, kk, rem, ac, sg, gat, gn, hold);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_prefix_limit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
